// File: rtl/fetch_instruction_memory.sv
// Clocked instruction store for the fetch stage: power-up fill, program-load port,
// registered read with stall hold and out-of-range fault. Optional macro: INSTR_MEM_PARITY_EN.
module fetch_instruction_memory #(
  parameter int               DATA_W    = 16,
  parameter int               ADDR_W    = 4,
  parameter int               PC_W      = 16,
  parameter logic [DATA_W-1:0] FILL_WORD = 16'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              fetch_stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`ifdef INSTR_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W:0]   clr_cnt_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_idx;

  // Out-of-range means any PC bit above the index field is set.
  generate
    if (PC_W > ADDR_W) begin : g_range
      assign in_range = ~|fetch_pc[PC_W-1:ADDR_W];
    end else begin : g_norange
      assign in_range = 1'b1;
    end
  endgenerate

  assign rd_idx = fetch_pc[ADDR_W-1:0];
  assign ready  = (state_reg == RUN);
  assign accept = ready & fetch_req & ~load_en & ~fetch_stall;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = load_addr;
    wr_data = load_data;
    if (rst_n) begin
      if (state_reg == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_reg[ADDR_W-1:0];
        wr_data = FILL_WORD;
      end else if (load_en) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + (ADDR_W+1)'(1);
      if (clr_cnt_reg == (ADDR_W+1)'(DEPTH-1)) begin
        state_reg <= RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (!fetch_stall) begin
      if (accept) begin
        instr_valid <= 1'b1;
        if (in_range) begin
          instr       <= mem[rd_idx];
          fetch_fault <= 1'b0;
        end else begin
          instr       <= FILL_WORD;
          fetch_fault <= 1'b1;
        end
      end else begin
        instr_valid <= 1'b0;
        fetch_fault <= 1'b0;
      end
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic chk_pending_reg;
  logic chk_par_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[wr_addr] <= ^wr_data;
    end
  end

  // Stored parity is compared against instr the cycle after it is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_pending_reg <= 1'b0;
      chk_par_reg     <= 1'b0;
      parity_err      <= 1'b0;
    end else begin
      chk_pending_reg <= accept & in_range;
      if (accept & in_range) begin
        chk_par_reg <= par_mem[rd_idx];
      end
      if (chk_pending_reg && ((^instr) != chk_par_reg)) begin
        parity_err <= 1'b1;
      end
    end
  end
`endif

endmodule
